rr_req_gnt_arbiter: RTL and testbench
=====================================

// Module: rr_req_gnt_arbiter
// PURPOSE
//  Parametrised N-channel request/grant responder with registered, round-robin grants.
//  Generalises the single-channel registered req->gnt responder to NUM_REQ requesters.
//  A grant is held while its owner keeps requesting, then handed off fairly.
//  Sits between bench/agent-driven req lines (clocking-block outputs) and shared resources.
// PARAMETERS
//  NUM_REQ   4   number of requesting channels, >= 2
//  IDW       $clog2(NUM_REQ)   width of gnt_id (derived, not overridden)
//  MAX_HOLD  8   max consecutive grant cycles per owner, >= 1; only used with RR_HOLD_LIMIT_EN
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  rst_n      in   1        synchronous reset, active low
//  req        in   NUM_REQ  request per channel; level, held until served
//  gnt        out  NUM_REQ  one-hot grant (or all-zero), registered
//  gnt_valid  out  1        |gnt, registered
//  gnt_id     out  IDW      index of granted channel; 0 when gnt_valid=0
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active low (rst_n): sampled only on posedge clk.
//  - Reset: gnt=0, gnt_valid=0, gnt_id=0, rr pointer=0 (ch0 highest priority), hold_cnt=0.
//  - No combinational path req->gnt. req sampled at posedge k drives gnt visible after posedge k.
//  - States: IDLE (gnt_valid=0), OWNED (gnt_valid=1, owner=gnt_id).
//  - IDLE: req==0 -> stay. req!=0 -> winner = first set bit scanning ptr, ptr+1, ...
//    (mod NUM_REQ). gnt=onehot(winner). ptr=(winner+1) mod NUM_REQ. -> OWNED.
//  - OWNED, req[owner]=1 -> hold grant unchanged; ptr unchanged.
//  - OWNED, req[owner]=0, other req set -> re-arbitrate on same edge. No idle bubble.
//  - OWNED, req==0 -> gnt=0 -> IDLE.
//  - ptr wraps NUM_REQ-1 -> 0. Requests arriving while owned wait; no pre-emption except below.
//  - Never more than one gnt bit set; gnt_id always matches gnt.
//  - rst_n low mid-grant: every register returns to its reset value on that edge. In-flight
//    grant is dropped with no hand-off.
// CONFIGURATION
//  - RR_HOLD_LIMIT_EN defined: hold_cnt counts consecutive owned cycles (1 on grant).
//    - When hold_cnt==MAX_HOLD and the owner still requests:
//      - another req set: owner is excluded from that edge's arbitration.
//        Winner by ptr scan; hold_cnt=1.
//      - only owner requests: owner re-granted, hold_cnt=1.
//    - hold_cnt saturates at MAX_HOLD; width $clog2(MAX_HOLD+1).
//  - RR_HOLD_LIMIT_EN undefined: no hold counter.
//    - An owner holds indefinitely while req[owner]=1. MAX_HOLD is ignored.
// TESTING (NUM_REQ=4, MAX_HOLD=4 unless noted)
//  1. rst_n=0 for 2 edges, req=4'hF -> gnt=0, gnt_valid=0 throughout.
//     First edge after release -> gnt=4'b0001, gnt_id=0.
//  2. From idle, req=4'b0100 sampled at edge k -> gnt=4'b0100, gnt_id=2, gnt_valid=1 after k.
//     req drops -> gnt=0 next edge.
//  3. req=4'hF; each owner drops its req for one cycle after being granted.
//     -> grant order 0,1,2,3,0 with no idle cycle between grants.
//  4. req=4'b0011 steady, macro off -> ch0 granted for all 20 cycles.
//     Macro on -> ch0 x4, ch1 x4, ch0 x4 ... alternating.
//  5. req=4'b0010 steady, macro on -> ch1 re-granted continuously; gnt never drops to 0.
//  6. ch2 owning, ptr=3; rst_n=0 for one edge with req=4'b1100 held -> gnt=0 on that edge.
//     Next edge -> gnt=4'b0100 (ptr reset to 0, scan finds ch2 first).

Source files
------------

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin request/grant arbiter with registered one-hot grants held while the owner requests.
// Optional RR_HOLD_LIMIT_EN caps consecutive owned cycles at MAX_HOLD before a fair hand-off.
module rr_req_gnt_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  output logic [IDW-1:0]     gnt_id_o
);

  if (NUM_REQ < 2 || MAX_HOLD < 1) begin : gen_param_check
    $error("rr_req_gnt_arbiter: NUM_REQ must be >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   cand;
  logic                 do_arb;
  logic [IDW-1:0]       win_id;

`ifdef RR_HOLD_LIMIT_EN
  localparam int unsigned HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HoldMax = HCW'(MAX_HOLD);
  logic [HCW-1:0] hold_q, hold_d;
`endif

  // First set bit of cand, scanning upward from ptr with wrap-around.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                             input logic [IDW-1:0]     ptr);
    logic        found;
    int unsigned j;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && c[j[IDW-1:0]]) begin
        found   = 1'b1;
        rr_pick = j[IDW-1:0];
      end
    end
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    int unsigned n;
    n = 32'(id) + 1;
    if (n >= NUM_REQ) n = 0;
    next_ptr = n[IDW-1:0];
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
`ifdef RR_HOLD_LIMIT_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
`ifdef RR_HOLD_LIMIT_EN
      hold_q   <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cand     = '0;
    do_arb   = 1'b0;
    win_id   = '0;
`ifdef RR_HOLD_LIMIT_EN
    hold_d   = hold_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          cand   = req_i;
          do_arb = 1'b1;
        end
      end
      StOwned: begin
        if (req_i[gnt_id_q]) begin
`ifdef RR_HOLD_LIMIT_EN
          if (hold_q == HoldMax) begin
            // Owner sits out this arbitration if anyone else is waiting.
            if (|(req_i & ~gnt_q)) begin
              cand   = req_i & ~gnt_q;
              do_arb = 1'b1;
            end else begin
              hold_d = HCW'(1);
            end
          end else begin
            hold_d = hold_q + HCW'(1);
          end
`else
          // Owner keeps the grant for as long as it requests.
          state_d = StOwned;
`endif
        end else if (|req_i) begin
          cand   = req_i;
          do_arb = 1'b1;
        end else begin
          state_d  = StIdle;
          gnt_d    = '0;
          gnt_id_d = '0;
`ifdef RR_HOLD_LIMIT_EN
          hold_d   = '0;
`endif
        end
      end
      default: begin
        state_d  = StIdle;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase

    if (do_arb) begin
      win_id         = rr_pick(cand, ptr_q);
      state_d        = StOwned;
      gnt_d          = '0;
      gnt_d[win_id]  = 1'b1;
      gnt_id_d       = win_id;
      ptr_d          = next_ptr(win_id);
`ifdef RR_HOLD_LIMIT_EN
      hold_d         = HCW'(1);
`endif
    end
  end

  always_comb begin
    gnt_o       = gnt_q;
    gnt_valid_o = (state_q == StOwned);
    gnt_id_o    = gnt_id_q;
  end

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Self-checking bench for rr_req_gnt_arbiter: directed vector table, corner sequences and
// randomized traffic against a behavioural round-robin model (honours RR_HOLD_LIMIT_EN).
module tb_rr_req_gnt_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned MH  = 4;
  localparam int unsigned IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;

  int checks   = 0;
  int failures = 0;

  // Reference model state: owner index (-1 = none), round-robin pointer, hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  typedef struct {
    logic         rst;
    logic [N-1:0] rq;
    logic [N-1:0] g;
    logic [1:0]   id;
    logic         vld;
  } vec_t;

  vec_t tbl[20];

  rr_req_gnt_arbiter #(
    .NUM_REQ (N),
    .MAX_HOLD(MH)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .gnt_o      (gnt),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic [N-1:0] rq);
    int excl;
    bit pick;
    logic [N-1:0] others;
    if (!r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      return;
    end
    excl = -1;
    pick = 1'b0;
    if (m_owner >= 0 && rq[m_owner]) begin
`ifdef RR_HOLD_LIMIT_EN
      others = rq;
      others[m_owner] = 1'b0;
      if (m_hold == MH) begin
        if (others != 0) begin
          excl = m_owner;
          pick = 1'b1;
        end else begin
          m_hold = 1;
        end
      end else begin
        m_hold = m_hold + 1;
      end
`else
      others = '0;
`endif
    end else begin
      pick = 1'b1;
    end
    if (pick) begin
      m_owner = -1;
      m_hold  = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (rq[c] && c != excl) begin
          m_owner = c;
          m_ptr   = (c + 1) % N;
          m_hold  = 1;
          break;
        end
      end
    end
  endtask

  function automatic logic [6:0] model_exp();
    logic [N-1:0] g;
    logic [1:0]   id;
    g  = '0;
    id = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      id = m_owner[1:0];
    end
    return {m_owner >= 0, id, g};
  endfunction

  task automatic step(input logic r, input logic [N-1:0] rq);
    @(negedge clk);
    rst_n = r;
    req   = rq;
    @(posedge clk);
    model_edge(r, rq);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {gnt_valid, gnt_id, gnt};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {valid,id,gnt}=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    logic [N-1:0] rr;
    logic         rs;
    logic [N-1:0] eg;

    rst_n = 1'b0;
    req   = '0;

    // Reset hold, release, idle grant, hand-off chain, reset mid-grant, wrap.
    tbl[0]  = '{1'b0, 4'hF, 4'h0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 4'h0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 4'h1, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 4'h4, 4'h4, 2'd2, 1'b1};
    tbl[5]  = '{1'b1, 4'h4, 4'h4, 2'd2, 1'b1};
    tbl[6]  = '{1'b1, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[8]  = '{1'b1, 4'hF, 4'h1, 2'd0, 1'b1};
    tbl[9]  = '{1'b1, 4'hE, 4'h2, 2'd1, 1'b1};
    tbl[10] = '{1'b1, 4'hD, 4'h4, 2'd2, 1'b1};
    tbl[11] = '{1'b1, 4'hB, 4'h8, 2'd3, 1'b1};
    tbl[12] = '{1'b1, 4'h7, 4'h1, 2'd0, 1'b1};
    tbl[13] = '{1'b1, 4'hE, 4'h2, 2'd1, 1'b1};
    tbl[14] = '{1'b1, 4'hC, 4'h4, 2'd2, 1'b1};
    tbl[15] = '{1'b0, 4'hC, 4'h0, 2'd0, 1'b0};
    tbl[16] = '{1'b1, 4'hC, 4'h4, 2'd2, 1'b1};
    tbl[17] = '{1'b1, 4'h8, 4'h8, 2'd3, 1'b1};
    tbl[18] = '{1'b1, 4'h1, 4'h1, 2'd0, 1'b1};
    tbl[19] = '{1'b1, 4'h0, 4'h0, 2'd0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].rq);
      check($sformatf("vec%0d", i), {tbl[i].vld, tbl[i].id, tbl[i].g});
    end

    // Two steady requesters: hold forever, or alternate every MH grants with the limit on.
    step(1'b0, 4'h3);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 4'h3);
`ifdef RR_HOLD_LIMIT_EN
      eg = ((c / MH) % 2 == 1) ? 4'h2 : 4'h1;
`else
      eg = 4'h1;
`endif
      check($sformatf("steady2_c%0d", c), {1'b1, (eg == 4'h2) ? 2'd1 : 2'd0, eg});
    end

    // Single steady requester never loses its grant, even at the hold limit.
    step(1'b0, 4'h2);
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 4'h2);
      check($sformatf("steady1_c%0d", c), {1'b1, 2'd1, 4'h2});
    end

    // Randomized traffic with sticky requests and rare resets against the model.
    step(1'b0, 4'h0);
    rr = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
      end
      rs = ($urandom_range(0, 99) != 0);
      step(rs, rr);
      check($sformatf("rand_c%0d", c), model_exp());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
